// File: rtl/cam_capture_rgb332.sv
// OV7670 capture: pairs RGB565 bytes into RGB332 pixels and writes them linearly to the frame buffer.
// Ports: clk/rst (sync high), enable, vsync, href, px_data in; mem_px_addr, mem_px_data, px_wr,
//   frame_done, frame_px_count, overflow out. Define CAM_COLORBAR_EN to add test_pattern (colour bars).
module cam_capture_rgb332 #(
    parameter int AW         = 15,
    parameter int DW         = 8,
    parameter int IMG_PIXELS = 19200
) (
`ifdef CAM_COLORBAR_EN
    input  logic          test_pattern,
`endif
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
    output logic [AW-1:0] mem_px_addr,
    output logic [DW-1:0] mem_px_data,
    output logic          px_wr,
    output logic          frame_done,
    output logic [AW:0]   frame_px_count,
    output logic          overflow
);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE} state_t;

    localparam logic [AW:0] IMG_CNT = (AW+1)'(IMG_PIXELS);
    localparam logic [AW:0] CNT_MAX = '1;

    state_t      state, state_nx;
    logic        phase;
    logic [5:0]  byte1;
    logic [AW:0] pix_cnt;
    logic        sof, eof, pix_ok, in_range;
    logic [7:0]  pix_val;

`ifdef CAM_COLORBAR_EN
    logic [7:0] x;
    logic [2:0] bar;
    assign bar = x[7:5];
`endif

    always_comb begin
        state_nx = state;
        sof      = 1'b0;
        eof      = 1'b0;
        unique case (state)
            IDLE:     if (enable && vsync) state_nx = WAIT_SOF;
            WAIT_SOF: if (!vsync) begin
                state_nx = CAPTURE;
                sof      = 1'b1;
            end
            CAPTURE:  if (vsync) begin
                eof      = 1'b1;
                state_nx = enable ? WAIT_SOF : IDLE;
            end
            default:  state_nx = IDLE;
        endcase
    end

    // vsync has priority: a byte arriving with vsync high is dropped
    assign pix_ok   = (state == CAPTURE) && !vsync && href && phase;
    assign in_range = pix_cnt < IMG_CNT;

    always_comb begin
        pix_val = {byte1, px_data[4:3]};
`ifdef CAM_COLORBAR_EN
        if (test_pattern)
            pix_val = {bar[2], bar[2], bar[2], bar[1], bar[1], bar[1], bar[0], bar[0]};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase          <= 1'b0;
            byte1          <= '0;
            pix_cnt        <= '0;
            mem_px_addr    <= '0;
            mem_px_data    <= '0;
            px_wr          <= 1'b0;
            frame_done     <= 1'b0;
            frame_px_count <= '0;
            overflow       <= 1'b0;
        end else begin
            px_wr      <= 1'b0;
            frame_done <= 1'b0;
            if (sof) begin
                pix_cnt <= '0;
                phase   <= 1'b0;
            end
            if (state == CAPTURE) begin
                // an odd trailing byte is lost when href drops
                if (vsync || !href) phase <= 1'b0;
                else                phase <= ~phase;
                if (!vsync && href && !phase)
                    byte1 <= {px_data[7:5], px_data[2:0]};
            end
            if (pix_ok) begin
                if (pix_cnt != CNT_MAX) pix_cnt <= pix_cnt + 1'b1;
                // beyond the frame size pixels are only counted
                if (in_range) begin
                    px_wr       <= 1'b1;
                    mem_px_addr <= pix_cnt[AW-1:0];
                    mem_px_data <= DW'(pix_val);
                end else begin
                    overflow <= 1'b1;
                end
            end
            if (eof) begin
                frame_done     <= 1'b1;
                frame_px_count <= pix_cnt;
            end
        end
    end

`ifdef CAM_COLORBAR_EN
    always_ff @(posedge clk) begin
        if (rst)
            x <= '0;
        else if (state != CAPTURE || vsync || !href)
            x <= '0;
        else if (pix_ok)
            x <= x + 8'd1;
    end
`endif

endmodule
